// File: rtl/pcpi_link_pkg.sv
// Definitions shared by the PCPI nibble-link transmitter and receiver:
// link widths and the handshake state encoding.
package pcpi_link_pkg;

  localparam int NIBBLE_W = 4;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    PRESENT,
    RELEASE
  } tx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level. The output resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state always uses non-blocking assignments, so every flop
  // samples the value that was present before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/pcpi_result_tx.sv
// Serializes a written-back PCPI result as LSB-first nibbles. Each nibble uses a
// four-phase valid/ack handshake with the host, and every ack wait is bounded by a timeout.
module pcpi_result_tx
  import pcpi_link_pkg::*;
#(
  parameter int NIBBLES     = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pcpi_ready,
  input  logic                         pcpi_wr,
  input  logic [NIBBLE_W*NIBBLES-1:0]  pcpi_rd,
  input  logic                         tx_ack,
  input  logic                         err_clr,
  output logic [NIBBLE_W-1:0]          tx_nibble,
  output logic                         tx_valid,
  output logic                         tx_busy,
  output logic                         tx_done,
  output logic                         err_overrun,
  output logic                         err_timeout
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  tx_state_t            r_state;
  tx_state_t            w_next_state;
  logic                 w_ack_s;
  logic [W-1:0]         r_shreg;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_wcnt;
  logic [NIBBLE_W-1:0]  r_tx_nibble;
  logic                 r_tx_done;
  logic                 r_err_overrun;
  logic                 r_err_timeout;
  logic                 w_completion;
  logic                 w_expired;
  logic                 w_last;
  logic                 w_timeout_evt;
  logic                 w_finish;

  sync_2ff u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tx_ack),
    .q     (w_ack_s)
  );

  assign w_completion = pcpi_ready && pcpi_wr;
  assign w_expired    = (r_wcnt == 8'(TIMEOUT_CYC - 1));
  assign w_last       = (r_idx == IDX_W'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every signal written here gets a default first; without it a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_timeout_evt = 1'b0;
    w_finish      = 1'b0;
    unique case (r_state)
      IDLE: if (w_completion) w_next_state = ARM;
      // ARM waits for the host to release ack before the first nibble is shown.
      ARM: begin
        if (!w_ack_s) w_next_state = PRESENT;
        else if (w_expired) begin
          w_next_state  = IDLE;
          w_timeout_evt = 1'b1;
        end
      end
      PRESENT: begin
        if (w_ack_s) w_next_state = RELEASE;
        else if (w_expired) begin
          w_next_state  = IDLE;
          w_timeout_evt = 1'b1;
        end
      end
      RELEASE: begin
        if (!w_ack_s) begin
          w_next_state = w_last ? IDLE : PRESENT;
          w_finish     = w_last;
        end else if (w_expired) begin
          w_next_state  = IDLE;
          w_timeout_evt = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (r_state == PRESENT);
    tx_busy  = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg       <= '0;
      r_idx         <= '0;
      r_wcnt        <= '0;
      r_tx_nibble   <= '0;
      r_tx_done     <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_tx_done <= w_finish;
      if (r_state != w_next_state) r_wcnt <= '0;
      else if (r_state != IDLE)    r_wcnt <= r_wcnt + 8'd1;

      if (r_state == IDLE && w_completion) begin
        r_shreg <= pcpi_rd;
        r_idx   <= '0;
      end

      // The nibble register only loads on PRESENT entry, so it is stable while valid.
      if (r_state == ARM && w_next_state == PRESENT) begin
        r_tx_nibble <= r_shreg[NIBBLE_W-1:0];
      end
      if (r_state == RELEASE && w_next_state == PRESENT) begin
        r_shreg     <= r_shreg >> NIBBLE_W;
        r_idx       <= r_idx + 1'b1;
        r_tx_nibble <= r_shreg[2*NIBBLE_W-1:NIBBLE_W];
      end

      // A new error event takes priority over a simultaneous clear.
      if (w_completion && r_state != IDLE) r_err_overrun <= 1'b1;
      else if (err_clr)                    r_err_overrun <= 1'b0;
      if (w_timeout_evt)                   r_err_timeout <= 1'b1;
      else if (err_clr)                    r_err_timeout <= 1'b0;
    end
  end

  assign tx_nibble   = r_tx_nibble;
  assign tx_done     = r_tx_done;
  assign err_overrun = r_err_overrun;
  assign err_timeout = r_err_timeout;

endmodule
